ioctl_upload_reader: RTL and testbench

IOCTL_UPLOAD_READER -- requirements
Module: ioctl_upload_reader

---
 rtl/ioctl_upload_reader_if.sv | 28 ++
 rtl/ioctl_upload_reader.sv | 127 ++++++++++++
 tb/tb_ioctl_upload_reader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_upload_reader_if.sv
// Signal bundle between the HPS upload port, the game CPU pause handshake and
// the game-RAM read port of ioctl_upload_reader.
interface ioctl_upload_reader_if #(
  parameter int AW = 12
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          paused;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_data;
  logic          timeout_flag;

  // Master is the surrounding system (HPS, CPU core, RAM); slave is the reader.
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, paused, ram_data,
    input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, timeout_flag
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, paused, ram_data,
    output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, timeout_flag
  );
endinterface

// File: rtl/ioctl_upload_reader.sv
// Serves HPS upload reads from a window of game RAM, halting the game CPU
// for the whole upload session and giving up on the halt after TIMEOUT clocks.
module ioctl_upload_reader #(
  parameter int            AW      = 12,
  parameter logic [AW-1:0] BASE    = '0,
  parameter int            LEN     = 256,
  parameter int            RD_LAT  = 1,
  parameter int            TIMEOUT = 4096
) (
  input logic                  clk_49m,
  input logic                  reset,
  ioctl_upload_reader_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmoCnt_q, tmoCnt_d;
  logic [1:0]    latCnt_q, latCnt_d;
  logic          outOfRange_q, outOfRange_d;
  logic [7:0]    din_q, din_d;
  logic [AW-1:0] ramAddr_q, ramAddr_d;
  logic          ramRd_q, ramRd_d;
  logic          pauseReq_q, pauseReq_d;
  logic          tmoFlag_q, tmoFlag_d;
  logic          addrInRange;

  // The full 25-bit offset is compared so high address bits can never alias into the window.
  assign addrInRange = {1'b0, bus.ioctl_addr} < 26'(LEN);

  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state_q      <= IDLE;
      tmoCnt_q     <= '0;
      latCnt_q     <= '0;
      outOfRange_q <= 1'b0;
      din_q        <= '0;
      ramAddr_q    <= '0;
      ramRd_q      <= 1'b0;
      pauseReq_q   <= 1'b0;
      tmoFlag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmoCnt_q     <= tmoCnt_d;
      latCnt_q     <= latCnt_d;
      outOfRange_q <= outOfRange_d;
      din_q        <= din_d;
      ramAddr_q    <= ramAddr_d;
      ramRd_q      <= ramRd_d;
      pauseReq_q   <= pauseReq_d;
      tmoFlag_q    <= tmoFlag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmoCnt_d     = tmoCnt_q;
    latCnt_d     = latCnt_q;
    outOfRange_d = outOfRange_q;
    din_d        = din_q;
    ramAddr_d    = ramAddr_q;
    ramRd_d      = 1'b0;
    tmoFlag_d    = tmoFlag_q;

    case (state_q)
      IDLE: begin
        if (bus.ioctl_upload) begin
          state_d   = PAUSE;
          tmoFlag_d = 1'b0;
          tmoCnt_d  = '0;
        end
      end
      PAUSE: begin
        if (bus.paused) begin
          state_d = READY;
        end else if (tmoCnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = READY;
          tmoFlag_d = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
      end
      // A read arriving together with the end of the session is still served.
      READY: begin
        if (bus.ioctl_rd) begin
          state_d      = FETCH;
          latCnt_d     = '0;
          outOfRange_d = !addrInRange;
          if (addrInRange) begin
            ramAddr_d = BASE + bus.ioctl_addr[AW-1:0];
            ramRd_d   = 1'b1;
          end else begin
            din_d = 8'hFF;
          end
        end else if (!bus.ioctl_upload) begin
          state_d = RELEASE;
        end
      end
      // latCnt counts FETCH cycles; RAM data is valid once it reaches RD_LAT.
      FETCH: begin
        if (outOfRange_q) begin
          state_d = READY;
        end else if (latCnt_q == 2'(RD_LAT)) begin
          din_d   = bus.ram_data;
          state_d = READY;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pauseReq_d = (state_d == PAUSE) || (state_d == READY) || (state_d == FETCH);
  end

  assign bus.ioctl_wait   = (state_q == PAUSE) || (state_q == FETCH) ||
                            ((state_q == READY) && bus.ioctl_rd);
  assign bus.ioctl_din    = din_q;
  assign bus.pause_req    = pauseReq_q;
  assign bus.ram_addr     = ramAddr_q;
  assign bus.ram_rd       = ramRd_q;
  assign bus.timeout_flag = tmoFlag_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Randomised self-checking bench for ioctl_upload_reader, compared against a
// transaction-level model of the upload read protocol.
`timescale 1ns/1ps
module tb_ioctl_upload_reader;

  localparam int            AW      = 12;
  localparam logic [AW-1:0] BASE    = 12'hF80;
  localparam int            LEN     = 256;
  localparam int            RD_LAT  = 1;
  localparam int            TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [4096];

  ioctl_upload_reader_if #(.AW(AW)) bus ();

  ioctl_upload_reader #(
    .AW(AW), .BASE(BASE), .LEN(LEN), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_49m(clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  // One-clock-latency RAM; garbage on every cycle that is not answering a strobe.
  always @(posedge clk) bus.ram_data <= bus.ram_rd ? mem[bus.ram_addr] : 8'($urandom);

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to be done", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit modelInRange(input logic [24:0] a);
    return int'(a) < LEN;
  endfunction

  function automatic logic [AW-1:0] modelRamAddr(input logic [24:0] a);
    return AW'((int'(BASE) + int'(a)) % (1 << AW));
  endfunction

  function automatic logic [7:0] modelByte(input logic [24:0] a);
    return modelInRange(a) ? mem[modelRamAddr(a)] : 8'hFF;
  endfunction

  function automatic int modelDoneCycle(input logic [24:0] a);
    return modelInRange(a) ? 2 + RD_LAT : 2;
  endfunction

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Issues one read at the current cycle T and observes the transaction until ioctl_wait drops.
  task automatic runRead(input logic [24:0] addr, input int dropAt,
                         output logic waitAtT, output int ramRdCount,
                         output logic [AW-1:0] ramAddrSeen, output logic [7:0] dinAtT1,
                         output int doneAt, output logic [7:0] dinDone);
    ramRdCount  = 0;
    ramAddrSeen = '0;
    dinAtT1     = '0;
    doneAt      = -1;
    dinDone     = '0;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = addr;
    if (dropAt == 0) bus.ioctl_upload = 1'b0;
    #1 waitAtT = bus.ioctl_wait;
    for (int k = 1; k <= 8 && doneAt < 0; k++) begin
      @(negedge clk);
      bus.ioctl_rd   = 1'b0;
      bus.ioctl_addr = 25'($urandom);
      if (dropAt == k) bus.ioctl_upload = 1'b0;
      #1;
      if (bus.ram_rd) begin
        ramRdCount++;
        ramAddrSeen = bus.ram_addr;
      end
      if (k == 1) dinAtT1 = bus.ioctl_din;
      if (!bus.ioctl_wait) begin
        doneAt  = k;
        dinDone = bus.ioctl_din;
      end
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (bus.ioctl_wait && n < 20) begin
      nextCycle();
      n++;
    end
    checks++;
    if (bus.ioctl_wait !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_ready: ioctl_wait=%b after %0d cycles, expected 0", tag, bus.ioctl_wait, n);
    end
  endtask

  task automatic closeSession();
    int n = 0;
    bus.ioctl_upload = 1'b0;
    nextCycle();
    while (bus.pause_req && n < 20) begin
      nextCycle();
      n++;
    end
    bus.paused = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset();
    foreach (mem[i]) mem[i] = 8'($urandom);
    reset = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.paused       = 1'b0;
    repeat (3) nextCycle();
    checks += 6;
    if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_pause_req: got %b expected 0", bus.pause_req); end
    if (bus.ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_rd: got %b expected 0", bus.ram_rd); end
    if (bus.ram_addr !== '0) begin errors++; $display("[TB] FAIL reset_ram_addr: got %h expected 000", bus.ram_addr); end
    if (bus.ioctl_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_din: got %h expected 00", bus.ioctl_din); end
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_flag: got %b expected 0", bus.timeout_flag); end
    if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL reset_wait: got %b expected 0", bus.ioctl_wait); end
    reset = 1'b1;
    nextCycle();
  endtask

  task automatic test_session_start();
    logic w; int cnt, done; logic [AW-1:0] ra; logic [7:0] d1, dd;
    bus.ioctl_upload = 1'b1;
    #1;
    checks += 2;
    if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL start_idle_pause_req: got %b expected 0", bus.pause_req); end
    if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL start_idle_wait: got %b expected 0", bus.ioctl_wait); end
    nextCycle();
    checks += 2;
    if (bus.pause_req !== 1'b1) begin errors++; $display("[TB] FAIL start_pause_req: got %b expected 1", bus.pause_req); end
    if (bus.ioctl_wait !== 1'b1) begin errors++; $display("[TB] FAIL start_pause_wait: got %b expected 1", bus.ioctl_wait); end
    nextCycle();
    nextCycle();
    bus.paused = 1'b1;
    nextCycle();
    checks += 2;
    if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL start_ready_wait: got %b expected 0", bus.ioctl_wait); end
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL start_timeout_flag: got %b expected 0", bus.timeout_flag); end
    mem[modelRamAddr(25'd5)] = 8'hA7;
    runRead(25'd5, -1, w, cnt, ra, d1, done, dd);
    checks += 5;
    if (w !== 1'b1) begin errors++; $display("[TB] FAIL first_wait_at_T: got %b expected 1", w); end
    if (cnt != 1) begin errors++; $display("[TB] FAIL first_ram_rd_count: got %0d expected 1", cnt); end
    if (ra !== modelRamAddr(25'd5)) begin errors++; $display("[TB] FAIL first_ram_addr: got %h expected %h", ra, modelRamAddr(25'd5)); end
    if (done != 3) begin errors++; $display("[TB] FAIL first_done_cycle: got T+%0d expected T+3", done); end
    if (dd !== 8'hA7) begin errors++; $display("[TB] FAIL first_din: got %h expected a7", dd); end
  endtask

  task automatic test_reads();
    logic [24:0] addrs[$];
    logic [24:0] addr;
    logic w; int cnt, done; logic [AW-1:0] ra; logic [7:0] d1, dd;
    addrs = '{25'd0, 25'(LEN - 1), 25'(LEN), 25'h1000005, 25'h1FFFFFF};
    for (int i = 0; i < 24; i++)
      addrs.push_back(($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, LEN - 1)));
    foreach (addrs[i]) begin
      addr = addrs[i];
      runRead(addr, -1, w, cnt, ra, d1, done, dd);
      checks += 4;
      if (w !== 1'b1) begin errors++; $display("[TB] FAIL read_wait_at_T addr=%h: got %b expected 1", addr, w); end
      if (cnt != (modelInRange(addr) ? 1 : 0)) begin errors++; $display("[TB] FAIL read_ram_rd_count addr=%h: got %0d expected %0d", addr, cnt, modelInRange(addr) ? 1 : 0); end
      if (done != modelDoneCycle(addr)) begin errors++; $display("[TB] FAIL read_done_cycle addr=%h: got T+%0d expected T+%0d", addr, done, modelDoneCycle(addr)); end
      if (dd !== modelByte(addr)) begin errors++; $display("[TB] FAIL read_din addr=%h: got %h expected %h", addr, dd, modelByte(addr)); end
      checks++;
      if (modelInRange(addr)) begin
        if (ra !== modelRamAddr(addr)) begin errors++; $display("[TB] FAIL read_ram_addr addr=%h: got %h expected %h", addr, ra, modelRamAddr(addr)); end
      end else begin
        if (d1 !== 8'hFF) begin errors++; $display("[TB] FAIL oor_din_at_T1 addr=%h: got %h expected ff", addr, d1); end
      end
      repeat ($urandom_range(0, 3)) nextCycle();
      checks++;
      if (bus.ioctl_din !== modelByte(addr)) begin errors++; $display("[TB] FAIL din_hold addr=%h: got %h expected %h", addr, bus.ioctl_din, modelByte(addr)); end
    end
  endtask

  task automatic test_wrap();
    logic w; int cnt, done; logic [AW-1:0] ra; logic [7:0] d1, dd;
    runRead(25'd200, -1, w, cnt, ra, d1, done, dd);
    checks += 2;
    if (ra !== 12'h048) begin errors++; $display("[TB] FAIL wrap_ram_addr: got %h expected 048", ra); end
    if (dd !== mem[12'h048]) begin errors++; $display("[TB] FAIL wrap_din: got %h expected %h", dd, mem[12'h048]); end
  endtask

  task automatic test_upload_fall();
    logic [24:0] addr;
    logic w; int cnt, done; logic [AW-1:0] ra; logic [7:0] d1, dd;
    for (int pass = 0; pass < 2; pass++) begin
      addr = 25'($urandom_range(0, LEN - 1));
      runRead(addr, pass, w, cnt, ra, d1, done, dd);
      checks += 3;
      if (done != modelDoneCycle(addr)) begin errors++; $display("[TB] FAIL fall%0d_done_cycle: got T+%0d expected T+%0d", pass, done, modelDoneCycle(addr)); end
      if (dd !== modelByte(addr)) begin errors++; $display("[TB] FAIL fall%0d_din: got %h expected %h", pass, dd, modelByte(addr)); end
      if (bus.pause_req !== 1'b1) begin errors++; $display("[TB] FAIL fall%0d_pause_at_done: got %b expected 1", pass, bus.pause_req); end
      nextCycle();
      checks += 2;
      if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL fall%0d_release_pause_req: got %b expected 0", pass, bus.pause_req); end
      if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL fall%0d_release_wait: got %b expected 0", pass, bus.ioctl_wait); end
      bus.ioctl_upload = 1'b1;
      bus.paused       = 1'b0;
      nextCycle();
      checks++;
      if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL fall%0d_via_idle: got pause_req %b expected 0", pass, bus.pause_req); end
      nextCycle();
      checks++;
      if (bus.pause_req !== 1'b1) begin errors++; $display("[TB] FAIL fall%0d_restart: got pause_req %b expected 1", pass, bus.pause_req); end
      bus.paused = 1'b1;
      waitReady("upload_fall");
    end
  endtask

  task automatic test_ignored_rd();
    closeSession();
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'd3;
    #1;
    checks++;
    if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_wait: got %b expected 0", bus.ioctl_wait); end
    nextCycle();
    bus.ioctl_rd = 1'b0;
    #1;
    checks += 2;
    if (bus.ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_ram_rd: got %b expected 0", bus.ram_rd); end
    if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_pause_req: got %b expected 0", bus.pause_req); end
    bus.ioctl_upload = 1'b1;
    nextCycle();
    bus.ioctl_rd = 1'b1;
    nextCycle();
    bus.ioctl_rd = 1'b0;
    #1;
    checks += 2;
    if (bus.ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL pause_rd_ram_rd: got %b expected 0", bus.ram_rd); end
    if (bus.ioctl_wait !== 1'b1) begin errors++; $display("[TB] FAIL pause_rd_still_pausing: got wait %b expected 1", bus.ioctl_wait); end
    bus.paused = 1'b1;
    waitReady("ignored_rd");
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [24:0] addr;
    logic w; int cnt, done; logic [AW-1:0] ra; logic [7:0] d1, dd;
    closeSession();
    bus.ioctl_upload = 1'b1;
    nextCycle();
    checks++;
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL tmo_flag_in_pause: got %b expected 0", bus.timeout_flag); end
    while (bus.ioctl_wait && n < TIMEOUT + 100) begin
      n++;
      nextCycle();
    end
    checks += 2;
    if (n != TIMEOUT) begin errors++; $display("[TB] FAIL tmo_pause_cycles: got %0d expected %0d", n, TIMEOUT); end
    if (bus.timeout_flag !== 1'b1) begin errors++; $display("[TB] FAIL tmo_flag_set: got %b expected 1", bus.timeout_flag); end
    addr = 25'($urandom_range(0, LEN - 1));
    runRead(addr, -1, w, cnt, ra, d1, done, dd);
    checks++;
    if (dd !== modelByte(addr)) begin errors++; $display("[TB] FAIL tmo_read_din: got %h expected %h", dd, modelByte(addr)); end
    closeSession();
    checks++;
    if (bus.timeout_flag !== 1'b1) begin errors++; $display("[TB] FAIL tmo_flag_sticky: got %b expected 1", bus.timeout_flag); end
    bus.ioctl_upload = 1'b1;
    nextCycle();
    checks++;
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL tmo_flag_cleared: got %b expected 0", bus.timeout_flag); end
    bus.paused = 1'b1;
    waitReady("timeout");
  endtask

  task automatic test_reset_mid_fetch();
    logic w; int cnt, done; logic [AW-1:0] ra; logic [7:0] d1, dd;
    runRead(25'(LEN), -1, w, cnt, ra, d1, done, dd);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'd7;
    nextCycle();
    bus.ioctl_rd = 1'b0;
    checks++;
    if (bus.ram_rd !== 1'b1) begin errors++; $display("[TB] FAIL rstfetch_strobe: got %b expected 1", bus.ram_rd); end
    reset = 1'b0;
    nextCycle();
    checks += 6;
    if (bus.ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_ram_rd: got %b expected 0", bus.ram_rd); end
    if (bus.ram_addr !== '0) begin errors++; $display("[TB] FAIL rstfetch_ram_addr: got %h expected 000", bus.ram_addr); end
    if (bus.ioctl_din !== 8'h00) begin errors++; $display("[TB] FAIL rstfetch_din: got %h expected 00", bus.ioctl_din); end
    if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_pause_req: got %b expected 0", bus.pause_req); end
    if (bus.timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_flag: got %b expected 0", bus.timeout_flag); end
    if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_wait: got %b expected 0", bus.ioctl_wait); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pause_req !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_pause_req_early: got %b expected 0", bus.pause_req); end
    nextCycle();
    checks += 2;
    if (bus.pause_req !== 1'b1) begin errors++; $display("[TB] FAIL rstrel_session_start: got pause_req %b expected 1", bus.pause_req); end
    if (bus.ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_ram_rd: got %b expected 0", bus.ram_rd); end
    nextCycle();
    checks += 2;
    if (bus.ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_ready_wait: got %b expected 0", bus.ioctl_wait); end
    if (bus.ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_ready_ram_rd: got %b expected 0", bus.ram_rd); end
  endtask

  initial begin
    test_reset();
    test_session_start();
    test_reads();
    test_wrap();
    test_upload_fall();
    test_ignored_rd();
    test_timeout();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
